uart_tx: RTL and testbench

- 8N1 UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Serialises bytes from a local producer onto the tx line; it is the transmit companion of the team's UART receiver and shares its clock and baud parameters.
- A one-entry holding register lets the producer queue the next byte while the current frame is on the line, so frames can be sent back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx - 8N1 UART transmitter (1 start, 8 data LSB first, 1 stop, no parity)
//
// Serialises bytes from a local producer onto the tx line. A one-entry
// holding register lets the producer queue the next byte while the current
// frame is on the line, so consecutive frames go out with no idle gap.
//
// Parameters:
//   SYS_CLOCK_FREQUENCY  system clock frequency in Hz
//   BAUD_RATE            line rate in bits/s
//   (BIT_TIME = SYS_CLOCK_FREQUENCY / BAUD_RATE clocks per bit, must be >= 2)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   data   in   byte to transmit, sampled on an accept edge (send & rdy)
//   send   in   request strobe from the producer
//   rdy    out  1 = holding register empty, a byte can be accepted
//   busy   out  1 = frame in progress or a byte is held
//   tx     out  serial line, idles high, registered
//   probe  out  current state code (IDLE=0, START=1, DATA=2, STOP=3)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int SYS_CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE           = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       send,
    output logic       rdy,
    output logic       busy,
    output logic       tx,
    output logic [3:0] probe
);

    localparam int          BIT_TIME = SYS_CLOCK_FREQUENCY / BAUD_RATE;
    localparam logic [31:0] LAST_CNT = 32'(BIT_TIME - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]  state;
    logic [7:0]  hold;
    logic        hold_valid;
    logic [7:0]  shift;
    logic [31:0] counter;
    logic [2:0]  bit_idx;

    logic        accept;
    logic        at_last;
    logic        load;
    logic [2:0]  next_idx;

    assign accept   = send & rdy;
    assign at_last  = (counter == LAST_CNT);
    assign next_idx = bit_idx + 3'd1;

    // A held byte moves into the shifter from IDLE, or straight out of the
    // last stop-bit cycle so back-to-back frames have no idle cycle between.
    assign load = hold_valid & ((state == IDLE) | ((state == STOP) & at_last));

    assign busy  = (state != IDLE) | hold_valid;
    assign probe = {2'b00, state};

    // Holding register. rdy is kept as a register alongside hold_valid so it
    // is a clean flop output. accept needs rdy=1 (hold empty) and load needs
    // hold_valid=1, so the two branches can never fire on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold       <= 8'h00;
            hold_valid <= 1'b0;
            rdy        <= 1'b1;
        end else if (accept) begin
            hold       <= data;
            hold_valid <= 1'b1;
            rdy        <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b0;
            rdy        <= 1'b1;
        end
    end

    // Frame sequencer. The counter runs 0..BIT_TIME-1 within every bit and
    // is cleared at each terminal count; tx is updated on that same edge so
    // each bit is on the line for exactly BIT_TIME cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift   <= 8'h00;
            counter <= 32'd0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    counter <= 32'd0;
                    if (load) begin
                        shift <= hold;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (at_last) begin
                        counter <= 32'd0;
                        tx      <= shift[0];
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end

                DATA: begin
                    if (at_last) begin
                        counter <= 32'd0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= shift[next_idx];
                        end
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end

                STOP: begin
                    if (at_last) begin
                        counter <= 32'd0;
                        if (hold_valid) begin
                            shift <= hold;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    counter <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx - self-checking bench for uart_tx at BIT_TIME = 16.
// A frame-level reference model predicts tx/rdy/busy/probe every cycle from
// the accepted-byte stream and the elapsed time since each frame started;
// a serial decoder recovers bytes from tx and checks them in order.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int BT = 16;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [7:0] data;
    logic       send;
    logic       rdy;
    logic       busy;
    logic       tx;
    logic [3:0] probe;

    uart_tx #(
        .SYS_CLOCK_FREQUENCY(1600),
        .BAUD_RATE          (100)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .send (send),
        .rdy  (rdy),
        .busy (busy),
        .tx   (tx),
        .probe(probe)
    );

    initial begin
        clk = 1'b0;
        forever #5 if (clk_en) clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    int         cyc      = 0;
    logic       m_hv     = 1'b0;
    logic [7:0] m_hold   = 8'h00;
    logic       m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_cur    = 8'h00;
    int         n_frames = 0;

    // serial decoder state
    logic [7:0] exp_rx[$];
    logic       rx_busy  = 1'b0;
    int         rx_cnt   = 0;
    logic [7:0] rx_byte  = 8'h00;
    int         rx_count = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        int   k;
        logic e_tx;
        logic [3:0] e_probe;
        e_tx    = 1'b1;
        e_probe = 4'd0;
        if (m_active) begin
            k = (cyc - m_start) / BT;
            if (k == 0)      begin e_tx = 1'b0;         e_probe = 4'd1; end
            else if (k <= 8) begin e_tx = m_cur[k - 1]; e_probe = 4'd2; end
            else             begin e_tx = 1'b1;         e_probe = 4'd3; end
        end
        chk("tx",    {7'd0, tx},   {7'd0, e_tx});
        chk("rdy",   {7'd0, rdy},  {7'd0, ~m_hv});
        chk("busy",  {7'd0, busy}, {7'd0, m_active | m_hv});
        chk("probe", {4'd0, probe}, {4'd0, e_probe});
    endtask

    // Mid-bit sampling receiver: start detected on the first low sample,
    // bit k sampled at k*BT + BT/2 samples later.
    task automatic decode();
        if (!rx_busy) begin
            if (tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BT == BT / 2) begin
                int k;
                k = rx_cnt / BT;
                if (k >= 1 && k <= 8) rx_byte[k - 1] = tx;
                if (k == 9) begin
                    chk("rx_stop", {7'd0, tx}, 8'd1);
                    if (exp_rx.size() == 0) begin
                        chk("rx_unexpected", rx_byte, 8'hxx);
                    end else begin
                        chk("rx_byte", rx_byte, exp_rx.pop_front());
                    end
                    rx_count++;
                    rx_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d);
        logic acc;
        send = s;
        data = d;
        @(posedge clk);
        cyc++;
        acc = s & ~m_hv;
        if (m_active && (cyc - m_start == 10 * BT)) m_active = 1'b0;
        if (!m_active && m_hv) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_cur    = m_hold;
            m_hv     = 1'b0;
            exp_rx.push_back(m_hold);
            n_frames++;
        end
        if (acc) begin
            m_hold = d;
            m_hv   = 1'b1;
        end
        @(negedge clk);
        check_outputs();
        decode();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((m_active || m_hv) && n < limit) begin
            step(1'b0, 8'($urandom));
            n++;
        end
        chk("idle_timeout", {7'd0, m_active | m_hv}, 8'd0);
        step(1'b0, 8'h00);
    endtask

    initial begin
        clk_en = 1'b0;
        send   = 1'b0;
        data   = 8'h00;
        rst    = 1'b1;

        // reset with the clock stopped
        #3 rst = 1'b0;
        #2;
        chk("rst_tx",    {7'd0, tx},    8'd1);
        chk("rst_rdy",   {7'd0, rdy},   8'd1);
        chk("rst_busy",  {7'd0, busy},  8'd0);
        chk("rst_probe", {4'd0, probe}, 8'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1'b0, 8'h00);

        // single byte
        step(1'b1, 8'hA5);
        wait_idle(400);

        // back-to-back, then overrun while hold is full
        step(1'b1, 8'h00);
        repeat (40) step(1'b0, 8'h00);
        step(1'b1, 8'hFF);
        repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        repeat (3) step(1'b1, 8'h3C);
        wait_idle(600);
        chk("b2b_frames", 8'(rx_count), 8'(n_frames));

        // reset mid-frame during data bit 3 with a byte held
        step(1'b1, 8'h96);
        step(1'b0, 8'h00);
        step(1'b1, 8'h4B);
        while (m_active && (cyc - m_start) < BT + 3 * BT + BT / 2) step(1'b0, 8'h00);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_tx",    {7'd0, tx},    8'd1);
        chk("mid_rst_rdy",   {7'd0, rdy},   8'd1);
        chk("mid_rst_busy",  {7'd0, busy},  8'd0);
        chk("mid_rst_probe", {4'd0, probe}, 8'd0);
        m_active = 1'b0;
        m_hv     = 1'b0;
        rx_busy  = 1'b0;
        exp_rx.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        wait_idle(400);

        // randomized traffic, including overruns
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) == 0), 8'($urandom));
        end
        wait_idle(800);
        chk("rx_pending", 8'(exp_rx.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
